// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: state encoding and shared constants for the SRAM port arbiter.
package sram_port_arbiter_pkg;
    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_TURN = 2'd1,
        S_INST = 2'd2
    } state_t;
    localparam logic [3:0] SEL_ALL = 4'b1111;
endpackage

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: merges the IF fetch port and MEM data port onto one SRAM port,
// data side first, with a bus-turnaround cycle after every write.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int WR_TURN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              stall_req_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_sel_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [CNT_W-1:0]  conflict_cnt_o
);
    state_t            state, state_nxt;
    logic [DATA_W-1:0] inst_hold, data_hold;
    logic [CNT_W-1:0]  conflict_cnt;
    logic              pend_data;
    logic              data_gnt, inst_gnt, conflict;

    assign data_gnt = state == S_ARB && mem_ce_i;
    assign inst_gnt = if_ce_i && ((state == S_ARB && !mem_ce_i) || state == S_INST);
    assign conflict = data_gnt && if_ce_i;

    always_ff @(posedge clk) begin
        state <= !rst_n ? S_ARB : state_nxt;
    end

    // The IF request stays asserted through the stall, so it marks an owed fetch in S_TURN.
    always_comb begin
        state_nxt = S_ARB;
        case (state)
            S_ARB:   state_nxt = (data_gnt && mem_we_i && WR_TURN != 0) ? S_TURN :
                                 conflict ? S_INST : S_ARB;
            S_TURN:  state_nxt = if_ce_i ? S_INST : S_ARB;
            default: state_nxt = S_ARB;
        endcase
    end

    always_comb begin
        ram_ce_o       = rst_n && (data_gnt || inst_gnt);
        ram_we_o       = rst_n && data_gnt && mem_we_i;
        ram_sel_o      = !rst_n ? 4'b0 : data_gnt ? mem_sel_i : inst_gnt ? SEL_ALL : 4'b0;
        ram_addr_o     = !rst_n ? '0 : data_gnt ? mem_addr_i : inst_gnt ? if_addr_i : '0;
        ram_wdata_o    = (rst_n && data_gnt && mem_we_i) ? mem_data_i : '0;
        mem_data_o     = !rst_n ? '0 : (data_gnt && !mem_we_i) ? ram_rdata_i : data_hold;
        if_data_o      = !rst_n ? '0 : inst_gnt ? ram_rdata_i : inst_hold;
        stall_req_o    = rst_n && (conflict || (state == S_ARB && pend_data) ||
                         (state == S_TURN && (if_ce_i || mem_ce_i)) ||
                         (state == S_INST && mem_ce_i));
        conflict_cnt_o = rst_n ? conflict_cnt : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_hold    <= '0;
            data_hold    <= '0;
            conflict_cnt <= '0;
            pend_data    <= 1'b0;
        end else begin
            if (inst_gnt) inst_hold <= ram_rdata_i;
            if (data_gnt && !mem_we_i) data_hold <= ram_rdata_i;
            if (conflict && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
            pend_data <= state == S_INST && mem_ce_i;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of the arbiter against a small word-addressed SRAM model.
module tb_sram_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_ce_i = 1'b1, mem_ce_i = 1'b1, mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = 4'b0;
    logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_data_i = '0;
    logic [31:0] if_data_o, mem_data_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic        stall_req_o, ram_ce_o, ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [15:0] conflict_cnt_o;
    logic [31:0] s_if_data, s_mem_data, s_addr, s_wdata;
    logic        s_stall, s_ce, s_we;
    logic [3:0]  s_sel;
    logic [1:0]  s_cnt;
    logic [31:0] mem [0:2047];
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .stall_req_o(stall_req_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .conflict_cnt_o(conflict_cnt_o)
    );

    // Narrow-counter instance sees identical traffic; only its counter is checked.
    sram_port_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(s_if_data),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_data_o(s_mem_data), .stall_req_o(s_stall),
        .ram_ce_o(s_ce), .ram_we_o(s_we), .ram_sel_o(s_sel), .ram_addr_o(s_addr),
        .ram_wdata_o(s_wdata), .ram_rdata_i(ram_rdata_i), .conflict_cnt_o(s_cnt)
    );

    assign ram_rdata_i = mem[ram_addr_o[12:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0]      <= 32'h11111111;
            mem[1]      <= 32'h22222222;
            mem[11'h400] <= 32'hDEADBEEF;
        end else if (ram_ce_o && ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel_o[b]) mem[ram_addr_o[12:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic ic, input logic [31:0] ia, input logic mc, input logic mw,
                       input logic [3:0] ms, input logic [31:0] ma, input logic [31:0] md);
        if_ce_i = ic; if_addr_i = ia; mem_ce_i = mc; mem_we_i = mw;
        mem_sel_i = ms; mem_addr_i = ma; mem_data_i = md;
    endtask

    initial begin
        // Reset held for two cycles with both requests asserted
        @(negedge clk);
        chk("rst_ram_ce", 32'(ram_ce_o), 32'd0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        chk("rst_cnt", 32'(conflict_cnt_o), 32'd0);
        nxt();
        @(negedge clk);
        chk("rst_ram_ce2", 32'(ram_ce_o), 32'd0);
        nxt();
        rst_n = 1'b1;
        // Fetch only
        req(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("f0_data", if_data_o, 32'h11111111);
        chk("f0_stall", 32'(stall_req_o), 32'd0);
        chk("f0_sel", 32'(ram_sel_o), 32'hF);
        nxt();
        if_addr_i = 32'h4;
        @(negedge clk);
        chk("f4_data", if_data_o, 32'h22222222);
        chk("f4_stall", 32'(stall_req_o), 32'd0);
        nxt();
        if_ce_i = 1'b0;
        @(negedge clk);
        chk("f_hold", if_data_o, 32'h22222222);
        chk("idle_ce", 32'(ram_ce_o), 32'd0);
        nxt();
        // Conflict read: data first, fetch in the following cycle
        req(1, 32'h4, 1, 0, 4'hF, 32'h1000, 32'h0);
        @(negedge clk);
        chk("cr_mem_data", mem_data_o, 32'hDEADBEEF);
        chk("cr_stall", 32'(stall_req_o), 32'd1);
        chk("cr_addr", ram_addr_o, 32'h1000);
        nxt();
        mem_ce_i = 1'b0;
        @(negedge clk);
        chk("cr_if_data", if_data_o, 32'h22222222);
        chk("cr_stall2", 32'(stall_req_o), 32'd0);
        chk("cr_addr2", ram_addr_o, 32'h4);
        chk("cr_cnt", 32'(conflict_cnt_o), 32'd1);
        chk("cr_sat_cnt", 32'(s_cnt), 32'd1);
        chk("cr_data_hold", mem_data_o, 32'hDEADBEEF);
        nxt();
        // Write with fetch pending: write, turnaround, fetch
        req(1, 32'h0, 1, 1, 4'hF, 32'h1000, 32'h00002333);
        @(negedge clk);
        chk("wr_ce", 32'(ram_ce_o), 32'd1);
        chk("wr_we", 32'(ram_we_o), 32'd1);
        chk("wr_wdata", ram_wdata_o, 32'h00002333);
        chk("wr_stall", 32'(stall_req_o), 32'd1);
        nxt();
        mem_ce_i = 1'b0;
        @(negedge clk);
        chk("turn_ce", 32'(ram_ce_o), 32'd0);
        chk("turn_stall", 32'(stall_req_o), 32'd1);
        nxt();
        @(negedge clk);
        chk("wf_ce", 32'(ram_ce_o), 32'd1);
        chk("wf_if_data", if_data_o, 32'h11111111);
        chk("wf_stall", 32'(stall_req_o), 32'd0);
        nxt();
        req(0, 32'h0, 1, 0, 4'hF, 32'h1000, 32'h0);
        @(negedge clk);
        chk("wr_readback", mem_data_o, 32'h00002333);
        nxt();
        // Single byte lane write
        req(0, 32'h0, 1, 1, 4'b0010, 32'h1000, 32'hAABBCCDD);
        @(negedge clk);
        chk("bl_sel", 32'(ram_sel_o), 32'h2);
        nxt();
        mem_ce_i = 1'b0;
        @(negedge clk);
        chk("bl_turn_ce", 32'(ram_ce_o), 32'd0);
        chk("bl_turn_stall", 32'(stall_req_o), 32'd0);
        nxt();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF;
        @(negedge clk);
        chk("bl_read", mem_data_o, 32'h0000CC33);
        nxt();
        // Data request arriving during the owed fetch is served next with stall
        req(1, 32'h0, 1, 0, 4'hF, 32'h1000, 32'h0);
        nxt();
        @(negedge clk);
        chk("pd_inst_stall", 32'(stall_req_o), 32'd1);
        chk("pd_inst_data", if_data_o, 32'h11111111);
        nxt();
        if_ce_i = 1'b0;
        @(negedge clk);
        chk("pd_arb_stall", 32'(stall_req_o), 32'd1);
        chk("pd_arb_data", mem_data_o, 32'h0000CC33);
        chk("pd_cnt", 32'(conflict_cnt_o), 32'd3);
        nxt();
        // Two more conflicts push the 2-bit counter past its ceiling
        for (int k = 0; k < 2; k++) begin
            req(1, 32'h4, 1, 0, 4'hF, 32'h1000, 32'h0);
            nxt();
            mem_ce_i = 1'b0;
            nxt();
        end
        if_ce_i = 1'b0;
        @(negedge clk);
        chk("sat_cnt", 32'(s_cnt), 32'd3);
        chk("wide_cnt", 32'(conflict_cnt_o), 32'd5);
        nxt();
        // Reset while in the turnaround state
        req(0, 32'h0, 1, 1, 4'hF, 32'h1000, 32'h00002333);
        nxt();
        rst_n = 1'b0; mem_ce_i = 1'b0;
        @(negedge clk);
        chk("rt_ce", 32'(ram_ce_o), 32'd0);
        chk("rt_stall", 32'(stall_req_o), 32'd0);
        nxt();
        rst_n = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'h0;
        @(negedge clk);
        chk("rt_arb_ce", 32'(ram_ce_o), 32'd1);
        chk("rt_arb_stall", 32'(stall_req_o), 32'd0);
        chk("rt_arb_data", if_data_o, 32'h11111111);
        chk("rt_cnt", 32'(conflict_cnt_o), 32'd0);
        nxt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
